// File: rtl/stb_gen.sv
// Strobe responder: emits one programmable-width strobe, waits a settle time,
// then returns synchronised master/slave comparator results with a valid pulse.
module stb_gen #(
    parameter int WIDTH_W     = 8,
    parameter int SETTLE_W    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                stb_req_i,
    input  logic                abort_i,
    input  logic [WIDTH_W-1:0]  pulse_width_i,
    input  logic [SETTLE_W-1:0] settle_cycles_i,
    input  logic                m_cmp_raw_i,
    input  logic                s_cmp_raw_i,
    output logic                stb_o,
    output logic                stb_valid_o,
    output logic                m_cmp_out_o,
    output logic                s_cmp_out_o,
    output logic                busy_o,
    output logic                ovr_o,
    input  logic                ovr_clr_i
);

    localparam int SYNC_W = $clog2(SYNC_STAGES) + 1;
    localparam int CNT_A  = (WIDTH_W > SETTLE_W) ? WIDTH_W : SETTLE_W;
    localparam int CNT_W  = (CNT_A > SYNC_W) ? CNT_A : SYNC_W;

    typedef enum logic [2:0] {IDLE, PULSE, SETTLE, SAMPLE, VALID} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic                 stb_q, stb_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 m_out_q, m_out_d;
    logic                 s_out_q, s_out_d;
    logic                 ovr_q, ovr_d;
    logic [SYNC_STAGES-1:0] m_sync_q, m_sync_d;
    logic [SYNC_STAGES-1:0] s_sync_q, s_sync_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        stb_d    = stb_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        m_out_d  = m_out_q;
        s_out_d  = s_out_q;
        ovr_d    = ovr_q;
        m_sync_d = {m_sync_q[SYNC_STAGES-2:0], m_cmp_raw_i};
        s_sync_d = {s_sync_q[SYNC_STAGES-2:0], s_cmp_raw_i};

        // Set is applied after clear so a simultaneous overrun wins.
        if (ovr_clr_i)
            ovr_d = 1'b0;
        if (stb_req_i && state_q != IDLE)
            ovr_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (stb_req_i && !abort_i) begin
                    state_d  = PULSE;
                    cnt_d    = (pulse_width_i == '0) ? '0 : CNT_W'(pulse_width_i - 1'b1);
                    settle_d = settle_cycles_i;
                    stb_d    = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    stb_d = 1'b0;
                    if (settle_q == '0) begin
                        state_d = SAMPLE;
                        cnt_d   = CNT_W'(SYNC_STAGES - 1);
                    end else begin
                        state_d = SETTLE;
                        cnt_d   = CNT_W'(settle_q - 1'b1);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                    cnt_d   = CNT_W'(SYNC_STAGES - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SAMPLE: begin
                if (cnt_q == '0) begin
                    state_d = VALID;
                    valid_d = 1'b1;
                    m_out_d = m_sync_q[SYNC_STAGES-1];
                    s_out_d = s_sync_q[SYNC_STAGES-1];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            VALID: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                stb_d   = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase

        // Abort discards any capture scheduled for this cycle.
        if (abort_i && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            stb_d   = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            m_out_d = m_out_q;
            s_out_d = s_out_q;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            settle_q <= '0;
            stb_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            m_out_q  <= 1'b0;
            s_out_q  <= 1'b0;
            ovr_q    <= 1'b0;
            m_sync_q <= '0;
            s_sync_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            stb_q    <= stb_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            m_out_q  <= m_out_d;
            s_out_q  <= s_out_d;
            ovr_q    <= ovr_d;
            m_sync_q <= m_sync_d;
            s_sync_q <= s_sync_d;
        end
    end

    assign stb_o       = stb_q;
    assign stb_valid_o = valid_q;
    assign m_cmp_out_o = m_out_q;
    assign s_cmp_out_o = s_out_q;
    assign busy_o      = busy_q;
    assign ovr_o       = ovr_q;

endmodule

// File: tb/tb_stb_gen.sv
// Directed bench for stb_gen: stimulus pushes expected results to a scoreboard,
// an independent monitor pops and compares on every stb_valid_o.
module tb_stb_gen;

    logic       clk_i = 1'b0;
    logic       arst_i = 1'b1;
    logic       stb_req_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [7:0] pulse_width_i = '0;
    logic [7:0] settle_cycles_i = '0;
    logic       m_cmp_raw_i = 1'b0;
    logic       s_cmp_raw_i = 1'b0;
    logic       ovr_clr_i = 1'b0;
    logic       stb_o, stb_valid_o, m_cmp_out_o, s_cmp_out_o, busy_o, ovr_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int   cyc;
        logic m;
        logic s;
    } exp_t;
    exp_t sb_q[$];

    stb_gen #(.WIDTH_W(8), .SETTLE_W(8), .SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .arst_i(arst_i), .stb_req_i(stb_req_i), .abort_i(abort_i),
        .pulse_width_i(pulse_width_i), .settle_cycles_i(settle_cycles_i),
        .m_cmp_raw_i(m_cmp_raw_i), .s_cmp_raw_i(s_cmp_raw_i),
        .stb_o(stb_o), .stb_valid_o(stb_valid_o), .m_cmp_out_o(m_cmp_out_o),
        .s_cmp_out_o(s_cmp_out_o), .busy_o(busy_o), .ovr_o(ovr_o), .ovr_clr_i(ovr_clr_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected transaction.
    always @(negedge clk_i) begin
        if (!arst_i && stb_valid_o) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", cyc, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("valid @%0d m=%0d s=%0d (expected @%0d m=%0d s=%0d)",
                         cyc, m_cmp_out_o, s_cmp_out_o, e.cyc, e.m, e.s);
                chk("valid_cycle", cyc, e.cyc);
                chk("m_cmp_out", m_cmp_out_o, e.m);
                chk("s_cmp_out", s_cmp_out_o, e.s);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Full strobe from request to idle; checks stb_o/busy_o every cycle.
    task automatic strobe_run(input int pw, input int st, input logic m_exp,
                              input logic s_exp, input int s_toggle_k);
        int w;
        w = (pw == 0) ? 1 : pw;
        pulse_width_i   = 8'(pw);
        settle_cycles_i = 8'(st);
        stb_req_i       = 1'b1;
        sb_q.push_back('{cyc + w + st + 3, m_exp, s_exp});
        for (int k = 0; k <= w + st + 4; k++) begin
            if (k == s_toggle_k) s_cmp_raw_i = 1'b1;
            @(negedge clk_i);
            chk("stb_o", stb_o, (k >= 1 && k <= w) ? 1 : 0);
            chk("busy_o", busy_o, (k >= 1 && k <= w + st + 3) ? 1 : 0);
            tick();
            stb_req_i       = 1'b0;
            pulse_width_i   = 8'hFF;
            settle_cycles_i = 8'hFF;
        end
        $display("strobe pw=%0d settle=%0d done", pw, st);
    endtask

    initial begin
        #2;
        chk("rst_stb", stb_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", stb_valid_o, 0);
        chk("rst_ovr", ovr_o, 0);
        #20 arst_i = 1'b0;
        tick(); tick();

        // 1: W=4 S=2, m=1 s=0 -> valid 9 cycles after request
        m_cmp_raw_i = 1'b1; s_cmp_raw_i = 1'b0;
        tick(); tick();
        strobe_run(4, 2, 1'b1, 1'b0, -1);

        // 2: width 0 behaves as 1, no settle -> valid at +4
        m_cmp_raw_i = 1'b0; s_cmp_raw_i = 1'b1;
        tick(); tick();
        strobe_run(0, 0, 1'b0, 1'b1, -1);

        // 3: overrun, clear, then set-wins-over-clear
        pulse_width_i = 8'd4; settle_cycles_i = 8'd2;
        sb_q.push_back('{cyc + 9, 1'b0, 1'b1});
        for (int k = 0; k <= 10; k++) begin
            stb_req_i = (k == 0 || k == 3 || k == 8);
            ovr_clr_i = (k == 6 || k == 8);
            @(negedge clk_i);
            chk("ovr_stb_o", stb_o, (k >= 1 && k <= 4) ? 1 : 0);
            chk("ovr_o", ovr_o, ((k >= 4 && k <= 6) || k >= 9) ? 1 : 0);
            tick();
        end
        stb_req_i = 1'b0;
        ovr_clr_i = 1'b1;
        tick();
        ovr_clr_i = 1'b0;
        @(negedge clk_i);
        chk("ovr_cleared", ovr_o, 0);
        tick();
        $display("overrun sequence done");

        // 6: s_raw rises during SETTLE and is captured
        m_cmp_raw_i = 1'b1; s_cmp_raw_i = 1'b0;
        tick(); tick();
        strobe_run(2, 4, 1'b1, 1'b1, 4);

        // 4: abort mid-pulse; outputs keep 1/1 even though raw inputs now read 0/0
        m_cmp_raw_i = 1'b0; s_cmp_raw_i = 1'b0;
        pulse_width_i = 8'd10; settle_cycles_i = 8'd2;
        for (int k = 0; k <= 18; k++) begin
            stb_req_i = (k == 0);
            abort_i   = (k == 5);
            @(negedge clk_i);
            chk("abort_stb_o", stb_o, (k >= 1 && k <= 5) ? 1 : 0);
            chk("abort_busy_o", busy_o, (k >= 1 && k <= 5) ? 1 : 0);
            tick();
        end
        abort_i = 1'b0;
        chk("abort_m_hold", m_cmp_out_o, 1);
        chk("abort_s_hold", s_cmp_out_o, 1);
        $display("abort sequence done");

        // abort together with request in IDLE: nothing happens
        stb_req_i = 1'b1; abort_i = 1'b1;
        tick();
        stb_req_i = 1'b0; abort_i = 1'b0;
        @(negedge clk_i);
        chk("idle_abort_busy", busy_o, 0);
        chk("idle_abort_stb", stb_o, 0);
        chk("idle_abort_ovr", ovr_o, 0);
        tick(); tick();
        $display("idle abort+req done");

        // 5: asynchronous reset mid-pulse, then a normal strobe
        m_cmp_raw_i = 1'b1; s_cmp_raw_i = 1'b0;
        pulse_width_i = 8'd8; settle_cycles_i = 8'd1;
        stb_req_i = 1'b1;
        tick();
        stb_req_i = 1'b0;
        @(negedge clk_i);
        chk("pre_rst_stb", stb_o, 1);
        tick();
        #2 arst_i = 1'b1;
        #1;
        chk("arst_stb", stb_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_m", m_cmp_out_o, 0);
        chk("arst_s", s_cmp_out_o, 0);
        chk("arst_ovr", ovr_o, 0);
        @(negedge clk_i);
        #1 arst_i = 1'b0;
        tick(); tick();
        $display("async reset done");
        strobe_run(3, 5, 1'b1, 1'b0, -1);

        tick(); tick();
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
